// File: rtl/idct8_serial_1d.sv
// Serial 8-point inverse DCT-II (VVC integer matrix): 8 coefficients in, 8 rounded residuals out.
// Optional macro IDCT8_CLIP_EN: saturate outputs to OUT_W instead of two's-complement wrap.
module idct8_serial_1d #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [IN_W-1:0]  in_data_i,
  input  logic                    in_last_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [OUT_W-1:0] out_data_o,
  output logic                    out_last_o,
  output logic                    err_last_o
);

  localparam int ACC_W = IN_W + 10;

  typedef enum logic [1:0] {
    S_ACC = 2'd0,
    S_RND = 2'd1,
    S_OUT = 2'd2
  } state_e;

  // One nibble per output n (n0 in bits 3:0): bit3 = negate, bits 2:0 = product select
  // 0:64 1:83 2:36 3:89 4:75 5:50 6:18
  localparam logic [31:0] COEF_ROW [8] = '{
    32'h0000_0000, 32'hBCDE_6543, 32'h12A9_9A21, 32'hC635_DBE4,
    32'h0880_0880, 32'hD3EC_46B5, 32'h291A_A192, 32'hE5C3_B4D6
  };

  state_e                   state_q, state_d;
  logic [2:0]               k_q, k_d;
  logic [2:0]               n_q, n_d;
  logic signed [ACC_W-1:0]  acc_q [8];
  logic signed [ACC_W-1:0]  acc_d [8];
  logic signed [OUT_W-1:0]  r_q [8];
  logic signed [OUT_W-1:0]  r_d [8];
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic                     err_q, err_d;

  logic signed [ACC_W-1:0]  x_s;
  logic signed [ACC_W-1:0]  p64_s, p83_s, p36_s, p89_s, p75_s, p50_s, p18_s;
  logic signed [ACC_W-1:0]  term_s [8];
  logic signed [OUT_W-1:0]  res_s [8];

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = {a[ACC_W-1], a} + ((ACC_W+1)'(1) << (SHIFT - 1));
    t = t >>> SHIFT;
    return t[ACC_W-1:0];
  endfunction

`ifdef IDCT8_CLIP_EN
  localparam logic signed [ACC_W-1:0] MAX_A = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_A = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] fit_out(input logic signed [ACC_W-1:0] v);
    logic signed [OUT_W-1:0] o;
    if (v > MAX_A) begin
      o = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (v < MIN_A) begin
      o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      o = v[OUT_W-1:0];
    end
    return o;
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] fit_out(input logic signed [ACC_W-1:0] v);
    return v[OUT_W-1:0];
  endfunction
`endif

  // Shared multiplier-free constant products of the incoming coefficient
  always_comb begin
    x_s   = {{(ACC_W-IN_W){in_data_i[IN_W-1]}}, in_data_i};
    p64_s = x_s <<< 6;
    p83_s = (x_s <<< 6) + (x_s <<< 4) + (x_s <<< 1) + x_s;
    p36_s = (x_s <<< 5) + (x_s <<< 2);
    p89_s = (x_s <<< 6) + (x_s <<< 4) + (x_s <<< 3) + x_s;
    p75_s = (x_s <<< 6) + (x_s <<< 3) + (x_s <<< 1) + x_s;
    p50_s = (x_s <<< 5) + (x_s <<< 4) + (x_s <<< 1);
    p18_s = (x_s <<< 4) + (x_s <<< 1);
  end

  // Per-output signed term c[k][n]*X[k] selected from the shared products
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      logic [3:0]              nib;
      logic signed [ACC_W-1:0] mag;
      nib = COEF_ROW[k_q][4*n +: 4];
      case (nib[2:0])
        3'd0:    mag = p64_s;
        3'd1:    mag = p83_s;
        3'd2:    mag = p36_s;
        3'd3:    mag = p89_s;
        3'd4:    mag = p75_s;
        3'd5:    mag = p50_s;
        3'd6:    mag = p18_s;
        default: mag = '0;
      endcase
      if (nib[3]) begin
        term_s[n] = -mag;
      end else begin
        term_s[n] = mag;
      end
    end
  end

  // Rounded, shifted and range-fitted view of every accumulator
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      res_s[n] = fit_out(round_shift(acc_q[n]));
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    acc_d       = acc_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    case (state_q)
      S_ACC: begin
        if (in_valid_i) begin
          for (int n = 0; n < 8; n++) begin
            acc_d[n] = acc_q[n] + term_s[n];
          end
          if (in_last_i != (k_q == 3'd7)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) begin
            state_d = S_RND;
          end else begin
            state_d = S_ACC;
          end
        end else begin
          state_d = S_ACC;
        end
      end
      S_RND: begin
        r_d         = res_s;
        out_data_d  = res_s[0];
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        n_d         = 3'd0;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready_i) begin
          if (n_q == 3'd7) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            for (int n = 0; n < 8; n++) begin
              acc_d[n] = '0;
            end
            k_d     = 3'd0;
            n_d     = 3'd0;
            state_d = S_ACC;
          end else begin
            n_d        = n_q + 3'd1;
            out_data_d = r_q[n_q + 3'd1];
            out_last_d = (n_q == 3'd6);
          end
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_ACC;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_ACC;
      k_q         <= 3'd0;
      n_q         <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        acc_q[n] <= '0;
        r_q[n]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      for (int n = 0; n < 8; n++) begin
        acc_q[n] <= acc_d[n];
        r_q[n]   <= r_d[n];
      end
    end
  end

  assign in_ready_o  = (state_q == S_ACC);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign err_last_o  = err_q;

endmodule
